// File: rtl/not_tmr_resync_ctrl.sv
// Resynchronisation controller for a triplicated design. It pulses resync on voter
// disagreement, retries a bounded number of times, then latches a permanent fault.
module not_tmr_resync_ctrl #(
    parameter int CNT_W        = 8,
    parameter int RESYNC_LEN   = 1,
    parameter int SETTLE_CYC   = 2,
    parameter int MAX_ATTEMPTS = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             err,
    input  logic             clr,
    output logic             resync,
    output logic             busy,
    output logic             irq,
    output logic [CNT_W-1:0] err_count,
    output logic             fault
);

    localparam int TMR_MAX = (RESYNC_LEN > SETTLE_CYC) ? RESYNC_LEN : SETTLE_CYC;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX + 1) : 1;
    localparam int ATT_W   = $clog2(MAX_ATTEMPTS + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RESYNC,
        ST_SETTLE,
        ST_FAULT
    } state_t;

    state_t           state_reg, state_next;
    logic [ATT_W-1:0] attempt_reg, attempt_next;
    logic [TMR_W-1:0] tmr_reg, tmr_next;
    logic [CNT_W-1:0] err_count_reg, err_count_next;
    logic             irq_reg, irq_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            attempt_reg   <= '0;
            tmr_reg       <= '0;
            err_count_reg <= '0;
            irq_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            attempt_reg   <= attempt_next;
            tmr_reg       <= tmr_next;
            err_count_reg <= err_count_next;
            irq_reg       <= irq_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        attempt_next   = attempt_reg;
        tmr_next       = tmr_reg;
        err_count_next = err_count_reg;
        irq_next       = 1'b0;

        // clr wipes the counter in every state; only FAULT also leaves its state
        if (clr) begin
            err_count_next = '0;
        end

        case (state_reg)
            ST_IDLE: begin
                if (err && !clr) begin
                    state_next   = ST_RESYNC;
                    attempt_next = ATT_W'(1);
                    tmr_next     = '0;
                    irq_next     = 1'b1;
                    if (err_count_reg != '1) begin
                        err_count_next = err_count_reg + CNT_W'(1);
                    end
                end
            end
            ST_RESYNC: begin
                if (tmr_reg == TMR_W'(RESYNC_LEN - 1)) begin
                    state_next = ST_SETTLE;
                    tmr_next   = '0;
                end else begin
                    tmr_next = tmr_reg + TMR_W'(1);
                end
            end
            ST_SETTLE: begin
                // err is only trusted on the final settle cycle
                if (tmr_reg == TMR_W'(SETTLE_CYC - 1)) begin
                    tmr_next = '0;
                    if (!err) begin
                        state_next   = ST_IDLE;
                        attempt_next = '0;
                    end else if (attempt_reg < ATT_W'(MAX_ATTEMPTS)) begin
                        state_next   = ST_RESYNC;
                        attempt_next = attempt_reg + ATT_W'(1);
                    end else begin
                        state_next = ST_FAULT;
                    end
                end else begin
                    tmr_next = tmr_reg + TMR_W'(1);
                end
            end
            ST_FAULT: begin
                if (clr) begin
                    state_next   = ST_IDLE;
                    attempt_next = '0;
                end
            end
            default: begin
                state_next   = ST_IDLE;
                attempt_next = '0;
                tmr_next     = '0;
            end
        endcase
    end

    assign resync    = (state_reg == ST_RESYNC);
    assign busy      = (state_reg != ST_IDLE);
    assign fault     = (state_reg == ST_FAULT);
    assign irq       = irq_reg;
    assign err_count = err_count_reg;

endmodule

// File: tb/tb_not_tmr_resync_ctrl.sv
// Directed bench for not_tmr_resync_ctrl: reset, transient and stuck errors,
// clear behaviour, counter saturation and asynchronous abort.
module tb_not_tmr_resync_ctrl;

    logic       clk;
    logic       rst_n;
    logic       err;
    logic       clr;
    logic       resync;
    logic       busy;
    logic       irq;
    logic [7:0] err_count;
    logic       fault;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int irq_seen;

    not_tmr_resync_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .err       (err),
        .clr       (clr),
        .resync    (resync),
        .busy      (busy),
        .irq       (irq),
        .err_count (err_count),
        .fault     (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // advance one cycle; inputs change and outputs are sampled 1 unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1;
        err   = 1'b0;
        clr   = 1'b0;

        // reset with no clock edge, random err/clr
        #1;
        rst_n = 1'b0;
        err   = 1'($urandom_range(0, 1));
        clr   = 1'($urandom_range(0, 1));
        #1;
        check("rst_resync", 32'(resync), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_irq", 32'(irq), 0);
        check("rst_count", 32'(err_count), 0);
        check("rst_fault", 32'(fault), 0);
        step();
        step();
        err   = 1'b0;
        clr   = 1'b0;
        rst_n = 1'b1;
        step();

        // transient error: err high in cycle 0 only
        err = 1'b1;
        step();
        err = 1'b0;
        $display("txn transient c1 resync=%0d irq=%0d cnt=%0d busy=%0d", resync, irq, err_count, busy);
        check("tr_c1_resync", 32'(resync), 1);
        check("tr_c1_irq", 32'(irq), 1);
        check("tr_c1_count", 32'(err_count), 1);
        check("tr_c1_busy", 32'(busy), 1);
        step();
        check("tr_c2_resync", 32'(resync), 0);
        check("tr_c2_irq", 32'(irq), 0);
        check("tr_c2_busy", 32'(busy), 1);
        step();
        check("tr_c3_resync", 32'(resync), 0);
        check("tr_c3_busy", 32'(busy), 1);
        step();
        check("tr_c4_busy", 32'(busy), 0);

        // clear counter in IDLE, then stuck error
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("idle_clr_count", 32'(err_count), 0);
        err = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            step();
            $display("txn stuck c%0d resync=%0d irq=%0d busy=%0d fault=%0d cnt=%0d",
                     c, resync, irq, busy, fault, err_count);
            check("stuck_resync", 32'(resync), 32'(c == 1 || c == 4 || c == 7));
            check("stuck_irq", 32'(irq), 32'(c == 1));
            check("stuck_busy", 32'(busy), 1);
            check("stuck_fault", 32'(fault), 32'(c >= 10));
            if (c >= 10) begin
                check("stuck_count", 32'(err_count), 1);
            end
        end

        // clear from FAULT
        err = 1'b0;
        clr = 1'b1;
        step();
        clr = 1'b0;
        $display("txn fault_clr fault=%0d cnt=%0d busy=%0d", fault, err_count, busy);
        check("fclr_fault", 32'(fault), 0);
        check("fclr_count", 32'(err_count), 0);
        check("fclr_busy", 32'(busy), 0);
        err = 1'b1;
        step();
        err = 1'b0;
        check("fclr_fresh_count", 32'(err_count), 1);
        check("fclr_fresh_irq", 32'(irq), 1);
        step();
        step();
        step();
        check("fclr_back_idle", 32'(busy), 0);

        // clr beats err in IDLE
        err = 1'b1;
        clr = 1'b1;
        step();
        err = 1'b0;
        clr = 1'b0;
        $display("txn clr_prio busy=%0d irq=%0d cnt=%0d", busy, irq, err_count);
        check("prio_busy", 32'(busy), 0);
        check("prio_irq", 32'(irq), 0);
        check("prio_count", 32'(err_count), 0);

        // saturation: 300 isolated events
        irq_seen = 0;
        for (int i = 0; i < 300; i++) begin
            err = 1'b1;
            step();
            err = 1'b0;
            if (irq) irq_seen++;
            if (i == 253) check("sat_count_254", 32'(err_count), 254);
            step();
            step();
            step();
        end
        $display("txn saturation cnt=%0d irqs=%0d", err_count, irq_seen);
        check("sat_count", 32'(err_count), 255);
        check("sat_irqs", 32'(irq_seen), 300);

        // asynchronous reset in the middle of RESYNC
        err = 1'b1;
        step();
        err = 1'b0;
        check("ar_pre_resync", 32'(resync), 1);
        #1;
        rst_n = 1'b0;
        #1;
        $display("txn async_rst resync=%0d busy=%0d cnt=%0d", resync, busy, err_count);
        check("ar_resync", 32'(resync), 0);
        check("ar_busy", 32'(busy), 0);
        check("ar_count", 32'(err_count), 0);
        step();
        rst_n = 1'b1;
        step();
        check("ar_idle_busy", 32'(busy), 0);
        err = 1'b1;
        step();
        err = 1'b0;
        check("ar_resume_resync", 32'(resync), 1);
        check("ar_resume_count", 32'(err_count), 1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
